fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 11, meaning instruction-memory word-address width.
REQ-002 SHALL have parameter INSTR_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning prefetch-queue entries (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins fetching at start_pc.
REQ-007 SHALL have port start_pc  in  PC_W  first fetch address.
REQ-008 SHALL have port redirect  in  1  branch/flush pulse from the memory stage.
REQ-009 SHALL have port redirect_pc  in  PC_W  new fetch address.
REQ-010 SHALL have port imem_req  out  1  fetch request valid.
REQ-011 SHALL have port imem_addr  out  PC_W  fetch address.
REQ-012 SHALL have port imem_gnt  in  1  request accepted this cycle.
REQ-013 SHALL have port imem_rvalid  in  1  read data valid.
REQ-014 SHALL have port imem_rdata  in  INSTR_W  read data.
REQ-015 SHALL have port instr_valid  out  1  queue head valid.
REQ-016 SHALL have port instr_ready  in  1  decode accepts head.
REQ-017 SHALL have port instr  out  INSTR_W  head instruction.
REQ-018 SHALL have port instr_pc  out  PC_W  address of head instruction.
REQ-019 SHALL have port busy  out  1  state is not IDLE.

Function
REQ-020 SHALL implement states IDLE, RUN, DRAIN.
REQ-021 IDLE: no requests; start=1 -> fetch_pc<=start_pc, go RUN; redirect ignored.
REQ-022 RUN: imem_req=1 when no request outstanding and (count + outstanding) < DEPTH; imem_addr=fetch_pc.
REQ-023 imem_req/imem_addr SHALL hold stable until imem_gnt; at gnt, outstanding<=1, fetch_pc<=fetch_pc+1 modulo 2^PC_W.
REQ-024 At most one request SHALL be outstanding; responses arrive in order, latency >=1 cycle after gnt.
REQ-025 imem_rvalid in RUN SHALL push {imem_rdata, request address} into the queue and clear outstanding.
REQ-026 instr_valid = (count != 0); instr/instr_pc = head entry; pop when instr_valid & instr_ready.
REQ-027 Push and pop in the same cycle SHALL leave count unchanged; count never exceeds DEPTH.
REQ-028 redirect in RUN SHALL empty the queue, set fetch_pc<=redirect_pc, and drop any unaccepted imem_req next cycle.
REQ-029 redirect with a granted-but-unreturned request (or gnt in the same cycle) SHALL go DRAIN; otherwise stay RUN.
REQ-030 DRAIN: imem_req=0; the next imem_rvalid SHALL be discarded, outstanding cleared, go RUN.
REQ-031 redirect in DRAIN SHALL update fetch_pc only; still discard exactly one response.
REQ-032 redirect coinciding with imem_rvalid SHALL discard that data and go RUN.
REQ-033 redirect coinciding with pop SHALL take priority; pop ignored.
REQ-034 start while busy SHALL be ignored.
REQ-035 Pointers SHALL wrap modulo DEPTH; instr_pc wraps modulo 2^PC_W.

Reset
REQ-036 rst_n=0 SHALL asynchronously force IDLE, fetch_pc=0, count=0, outstanding=0, pointers=0.
REQ-037 During reset: imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, busy=0.
REQ-038 Reset mid-request SHALL abandon it; a response arriving in IDLE SHALL be ignored.

Verification
REQ-039 start_pc=0x010, gnt same cycle, rvalid next cycle, instr_ready=1 -> instr_pc 0x010,0x011,0x012 in order, one instr per 2 cycles.
REQ-040 DEPTH=4, instr_ready=0 -> exactly 4 entries fetched, imem_req stays 0, instr_pc holds 0x010 until ready.
REQ-041 PC_W=11, start_pc=0x7FE -> instr_pc sequence 0x7FE,0x7FF,0x000.
REQ-042 redirect_pc=0x100 while request outstanding -> state DRAIN, returning word discarded, next instr_pc=0x100.
REQ-043 redirect, rvalid and pop in same cycle -> queue empty next cycle, data dropped, fetch resumes at redirect_pc.
REQ-044 rst_n low mid-fetch with 3 queued -> immediately instr_valid=0, imem_req=0, busy=0; late rvalid ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requester feeding an
// in-order prefetch queue, with redirect/flush handling via a DRAIN state.
module fetch_unit #(
  parameter int PC_W    = 11,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic          out_q, out_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0][INSTR_W-1:0] q_data_q;
  logic [DEPTH-1:0][PC_W-1:0]    q_pc_q;

  logic          push, pop, gnt_fire;
  logic [CW:0]   inflight;

  assign inflight    = {1'b0, cnt_q} + {{CW{1'b0}}, out_q};
  assign imem_req    = (state_q == S_RUN) && !out_q && (inflight < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc_q;
  assign gnt_fire    = imem_req && imem_gnt;
  assign instr_valid = (cnt_q != '0);
  assign pop         = instr_valid && instr_ready;
  // Head is gated so empty/reset queue presents zeros rather than stale storage.
  assign instr       = instr_valid ? q_data_q[rptr_q] : '0;
  assign instr_pc    = instr_valid ? q_pc_q[rptr_q]   : '0;
  assign busy        = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    out_d      = out_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          fetch_pc_d = start_pc;
        end
      end
      S_RUN: begin
        if (redirect) begin
          // Flush wins over any same-cycle push or pop.
          fetch_pc_d = redirect_pc;
          cnt_d      = '0;
          wptr_d     = '0;
          rptr_d     = '0;
          if (out_q && imem_rvalid) begin
            out_d = 1'b0;
          end else if (out_q || gnt_fire) begin
            out_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end else begin
          if (gnt_fire) begin
            out_d      = 1'b1;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 1'b1;
          end
          if (out_q && imem_rvalid) begin
            push  = 1'b1;
            out_d = 1'b0;
          end
          if (push) wptr_d = wptr_q + 1'b1;
          if (pop)  rptr_d = rptr_q + 1'b1;
          if (push && !pop)      cnt_d = cnt_q + 1'b1;
          else if (pop && !push) cnt_d = cnt_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (redirect) fetch_pc_d = redirect_pc;
        if (imem_rvalid) begin
          out_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      out_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      out_q      <= out_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data_q[wptr_q] <= imem_rdata;
      q_pc_q[wptr_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the bench plays instruction memory with a
// programmable response latency and checks hand-computed expectations.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, redirect, imem_gnt, imem_rvalid, instr_ready;
  logic [10:0] start_pc, redirect_pc;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid, busy;
  logic [10:0] imem_addr, instr_pc;
  logic [31:0] instr;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int wait_c = 0;
  bit pend = 0;
  logic [10:0] paddr = '0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(11), .INSTR_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .busy(busy)
  );

  function automatic logic [31:0] data_of(input logic [10:0] a);
    return 32'hA000_0000 | {21'd0, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: capture any handshake, cross the edge, then model memory.
  task automatic cyc();
    bit fired;
    logic [10:0] a;
    #1;
    fired = imem_req && imem_gnt;
    a     = imem_addr;
    @(posedge clk); #1;
    start       = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    if (fired) begin
      pend = 1; paddr = a; wait_c = lat;
    end
    if (pend) begin
      if (wait_c <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = data_of(paddr);
        pend        = 0;
      end else begin
        wait_c--;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 0; redirect = 0; imem_rvalid = 0; instr_ready = 0;
    imem_gnt = 1; start_pc = '0; redirect_pc = '0; imem_rdata = '0;
    pend = 0; lat = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state and redirect ignored in IDLE
    rst_n = 1'b0;
    start = 0; redirect = 0; imem_rvalid = 0; instr_ready = 0;
    imem_gnt = 1; start_pc = '0; redirect_pc = '0; imem_rdata = '0;
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    do_reset();
    redirect = 1; redirect_pc = 11'h055;
    cyc();
    chk("idle_redir_busy", 32'(busy), 32'd0);
    chk("idle_redir_req", 32'(imem_req), 32'd0);

    // Streaming: one instruction every two cycles
    do_reset();
    instr_ready = 1; start = 1; start_pc = 11'h010;
    cyc();
    chk("s_busy", 32'(busy), 32'd1);
    chk("s_req", 32'(imem_req), 32'd1);
    chk("s_addr", 32'(imem_addr), 32'h010);
    cyc();
    chk("s_req_out", 32'(imem_req), 32'd0);
    cyc();
    chk("s_v0", 32'(instr_valid), 32'd1);
    chk("s_pc0", 32'(instr_pc), 32'h010);
    chk("s_i0", instr, 32'hA000_0010);
    chk("s_addr1", 32'(imem_addr), 32'h011);
    cyc();
    chk("s_gap", 32'(instr_valid), 32'd0);
    cyc();
    chk("s_pc1", 32'(instr_pc), 32'h011);
    cyc(); cyc();
    chk("s_pc2", 32'(instr_pc), 32'h012);

    // Backpressure: queue fills to DEPTH, requests stop
    do_reset();
    start = 1; start_pc = 11'h010;
    repeat (12) cyc();
    chk("f_valid", 32'(instr_valid), 32'd1);
    chk("f_pc", 32'(instr_pc), 32'h010);
    chk("f_req", 32'(imem_req), 32'd0);
    chk("f_addr", 32'(imem_addr), 32'h014);
    start = 1; start_pc = 11'h3FF;
    cyc();
    chk("f_start_ignored", 32'(imem_addr), 32'h014);
    instr_ready = 1;
    cyc();
    chk("f_pop_pc", 32'(instr_pc), 32'h011);
    chk("f_req_resume", 32'(imem_req), 32'd1);
    chk("f_addr_resume", 32'(imem_addr), 32'h014);

    // PC wrap
    do_reset();
    instr_ready = 1; start = 1; start_pc = 11'h7FE;
    cyc(); cyc(); cyc();
    chk("w_pc0", 32'(instr_pc), 32'h7FE);
    cyc(); cyc();
    chk("w_pc1", 32'(instr_pc), 32'h7FF);
    cyc(); cyc();
    chk("w_pc2", 32'(instr_pc), 32'h000);

    // Redirect with request outstanding -> DRAIN, discard one word
    do_reset();
    lat = 3; start = 1; start_pc = 11'h010;
    cyc(); cyc();
    redirect = 1; redirect_pc = 11'h100;
    cyc();
    chk("d_busy", 32'(busy), 32'd1);
    chk("d_req", 32'(imem_req), 32'd0);
    chk("d_valid", 32'(instr_valid), 32'd0);
    cyc();
    chk("d_rvalid_req", 32'(imem_req), 32'd0);
    cyc();
    chk("d_discard", 32'(instr_valid), 32'd0);
    chk("d_req_new", 32'(imem_req), 32'd1);
    chk("d_addr_new", 32'(imem_addr), 32'h100);
    lat = 1; instr_ready = 1;
    cyc(); cyc();
    chk("d_pc", 32'(instr_pc), 32'h100);
    chk("d_instr", instr, 32'hA000_0100);

    // Redirect + rvalid + pop in one cycle
    do_reset();
    start = 1; start_pc = 11'h010;
    cyc(); cyc(); cyc(); cyc();
    chk("x_pre_pc", 32'(instr_pc), 32'h010);
    chk("x_pre_rv", 32'(imem_rvalid), 32'd1);
    redirect = 1; redirect_pc = 11'h200; instr_ready = 1;
    cyc();
    chk("x_empty", 32'(instr_valid), 32'd0);
    chk("x_req", 32'(imem_req), 32'd1);
    chk("x_addr", 32'(imem_addr), 32'h200);
    cyc(); cyc();
    chk("x_pc", 32'(instr_pc), 32'h200);

    // Async reset mid-fetch with 3 queued, late response ignored
    do_reset();
    start = 1; start_pc = 11'h010;
    repeat (8) cyc();
    chk("r_pre_pc", 32'(instr_pc), 32'h010);
    chk("r_pre_rv", 32'(imem_rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("r_valid", 32'(instr_valid), 32'd0);
    chk("r_req", 32'(imem_req), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    imem_rvalid = 1'b0; pend = 0;
    #1;
    chk("r_late_valid", 32'(instr_valid), 32'd0);
    chk("r_late_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
